// File: rtl/mds_seq.sv
`default_nettype none
// ============================================================================
// Module   : mds_seq
// Desc     : Twofish MDS matrix multiplier, one GF(2^8) output row per clock
// Revision : 1.0 - initial release
// ============================================================================
module mds_seq #(
    parameter logic [7:0] POLY = 8'h69
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-lane coefficient codes; a row is four of these packed {y3,y2,y1,y0}
    localparam logic [1:0] C_01 = 2'd0;
    localparam logic [1:0] C_5B = 2'd1;
    localparam logic [1:0] C_EF = 2'd2;

    state_t      state_q, state_d;
    logic [1:0]  row_q, row_d;
    logic [31:0] din_q, din_d;
    logic [31:0] dout_q, dout_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  row_coef;
    logic [31:0] terms;
    logic [7:0]  z_row;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
    endfunction

    // 0x5B = x^6 + x^4 + x^3 + x + 1
    function automatic logic [7:0] mul_5b(input logic [7:0] a);
        logic [7:0] x1, x2, x3, x4, x5, x6;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        x4 = xtime(x3);
        x5 = xtime(x4);
        x6 = xtime(x5);
        return a ^ x1 ^ x3 ^ x4 ^ x6;
    endfunction

    // 0xEF = x^7 + x^6 + x^5 + x^3 + x^2 + x + 1
    function automatic logic [7:0] mul_ef(input logic [7:0] a);
        logic [7:0] x1, x2, x3, x4, x5, x6, x7;
        x1 = xtime(a);
        x2 = xtime(x1);
        x3 = xtime(x2);
        x4 = xtime(x3);
        x5 = xtime(x4);
        x6 = xtime(x5);
        x7 = xtime(x6);
        return a ^ x1 ^ x2 ^ x3 ^ x5 ^ x6 ^ x7;
    endfunction

    always_comb begin
        row_coef = {C_5B, C_5B, C_EF, C_01};
        case (row_q)
            2'd0:    row_coef = {C_5B, C_5B, C_EF, C_01};
            2'd1:    row_coef = {C_01, C_EF, C_EF, C_5B};
            2'd2:    row_coef = {C_EF, C_01, C_5B, C_EF};
            default: row_coef = {C_5B, C_EF, C_01, C_EF};
        endcase
    end

    // One shared row datapath: each lane offers 01/5B/EF products, row picks one
    for (genvar j = 0; j < 4; j++) begin : g_lane
        logic [7:0] y;
        logic [7:0] y_5b;
        logic [7:0] y_ef;
        logic [1:0] code;

        assign y    = din_q[8*j +: 8];
        assign y_5b = mul_5b(y);
        assign y_ef = mul_ef(y);
        assign code = row_coef[2*j +: 2];
        assign terms[8*j +: 8] = (code == C_01) ? y    :
                                 (code == C_5B) ? y_5b : y_ef;
    end

    assign z_row = terms[7:0] ^ terms[15:8] ^ terms[23:16] ^ terms[31:24];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        din_d   = din_q;
        dout_d  = dout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    din_d   = din;
                    row_d   = 2'd0;
                    state_d = CALC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                dout_d[{row_q, 3'b000} +: 8] = z_row;
                row_d = row_q + 2'd1;
                if (row_q == 2'd3) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
            din_q   <= 32'h0;
            dout_q  <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_mds_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mds_seq
// Desc     : Self-checking bench for mds_seq (table vectors + corner sequences)
// Revision : 1.0 - initial release
// ============================================================================
module tb_mds_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mds_seq #(.POLY(8'h69)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Bit-serial shift-and-add multiply modulo x^8+x^6+x^5+x^3+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] r;
        r  = 8'h00;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h169;
        end
        return r;
    endfunction

    function automatic logic [31:0] mds_model(input logic [31:0] x);
        logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
        y0 = x[7:0]; y1 = x[15:8]; y2 = x[23:16]; y3 = x[31:24];
        z0 = gmul(8'h01, y0) ^ gmul(8'hEF, y1) ^ gmul(8'h5B, y2) ^ gmul(8'h5B, y3);
        z1 = gmul(8'h5B, y0) ^ gmul(8'hEF, y1) ^ gmul(8'hEF, y2) ^ gmul(8'h01, y3);
        z2 = gmul(8'hEF, y0) ^ gmul(8'h5B, y1) ^ gmul(8'h01, y2) ^ gmul(8'hEF, y3);
        z3 = gmul(8'hEF, y0) ^ gmul(8'h01, y1) ^ gmul(8'hEF, y2) ^ gmul(8'h5B, y3);
        return {z3, z2, z1, z0};
    endfunction

    // Wait up to 8 edges for done; returns edges waited (0 = timed out)
    task automatic wait_done(output int lat, output logic both);
        lat  = 0;
        both = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (busy && done) both = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] d, input logic [31:0] exp, input string nm);
        int   lat;
        logic both;
        start = 1'b1;
        din   = d;
        @(posedge clk); #1;
        start = 1'b0;
        din   = $urandom;
        wait_done(lat, both);
        chk({nm, " latency"}, lat, 4);
        chk({nm, " dout"}, dout, exp);
        chk({nm, " busy&done"}, {31'h0, both}, 32'h0);
        @(posedge clk); #1;
        chk({nm, " done width"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        int          lat;
        int          t_prev;
        int          seen;
        logic        both;
        logic [31:0] prev;
        logic [31:0] vb [3];

        tbl[0] = '{32'h00000000, 32'h00000000};
        tbl[1] = '{32'h00000001, 32'hEFEF5B01};
        tbl[2] = '{32'h00000100, 32'h015BEFEF};
        tbl[3] = '{32'h00010000, 32'hEF01EF5B};
        tbl[4] = '{32'h01000000, 32'h5BEF015B};
        tbl[5] = '{32'h00000002, 32'hB7B7B602};
        tbl[6] = '{32'h01010101, 32'h5A5A5AEE};
        tbl[7] = '{32'h00000003, 32'h5858ED03};

        // Reset with garbage on the inputs
        rst_n = 1'b0;
        start = 1'b1;
        din   = $urandom;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", dout, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle after reset", {dout[31:2], busy, done}, 32'h0);
        end

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));

        // dout holds in IDLE
        repeat (6) @(posedge clk);
        #1;
        chk("idle hold", dout, 32'h5858ED03);

        // Per-lane sweep against the bench model
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 256; v++) begin
                logic [31:0] d;
                d = 32'(v) << (8 * k);
                run_op(d, mds_model(d), $sformatf("sweep lane%0d v%02h", k, v));
            end
        end

        // Start during CALC with a different din must be ignored and not queued
        start = 1'b1;
        din   = 32'h00000001;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        din   = 32'h00000100;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, both);
        chk("ignored start latency", lat, 2);
        chk("ignored start dout", dout, 32'hEFEF5B01);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("ignored start not queued", seen, 0);

        // start held high: three back-to-back operations 5 cycles apart
        vb[0] = 32'h00000002;
        vb[1] = 32'h01010101;
        vb[2] = 32'h00010000;
        start  = 1'b1;
        din    = vb[0];
        t_prev = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            wait_done(lat, both);
            chk($sformatf("b2b%0d dout", i), dout, mds_model(vb[i]));
            chk($sformatf("b2b%0d busy&done", i), {31'h0, both}, 32'h0);
            if (i == 0) chk("b2b0 latency", lat, 4);
            else        chk($sformatf("b2b%0d interval", i), cyc - t_prev, 5);
            t_prev = cyc;
            if (i < 2) din = vb[i+1];
            else       start = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b idle after", {30'h0, busy, done}, 32'h0);

        // Abort after row 1; partial dout mixes new low rows with old high rows
        prev  = dout;
        start = 1'b1;
        din   = 32'h00000003;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("partial dout", dout, {prev[31:16], 16'hED03});
        rst_n = 1'b0;
        #1;
        chk("abort dout", dout, 32'h0);
        chk("abort flags", {30'h0, busy, done}, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy || (dout != 32'h0)) seen++;
        end
        chk("post-abort idle", seen, 0);
        run_op(32'h01010101, 32'h5A5A5AEE, "post-abort op");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mds_seq.md
Name: mds_seq

Overview:
- Sequential Twofish MDS matrix multiplier. Computes the 32-bit MDS result for one 32-bit input word, one output row per clock, using GF(2^8) constant multipliers by 01, 5B and EF.
- Sits between the S-box stage and the PHT in the h/g-function datapath.
- Trades the four parallel MDS rows of a fully combinational block for one shared row datapath and a start/done handshake.

Parameters:
- POLY, 8'h69, low 8 bits of the GF(2^8) reduction polynomial; the x^8 term is implicit. The default gives x^8+x^6+x^5+x^3+1 (0x169).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- din  input  32  input vector; y0 = din[7:0] … y3 = din[31:24]
- busy  output  1  high while rows are being computed
- done  output  1  one-cycle pulse when dout is complete
- dout  output  32  result; z0 = dout[7:0] … z3 = dout[31:24]

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, row=0, din_q=0, dout=0, busy=0, done=0.
- Reset asserted mid-computation aborts the operation immediately. After release the block sits in IDLE with dout=0 and no done pulse.
- MDS rows (coefficients for y0 y1 y2 y3):
  - row0: 01 EF 5B 5B
  - row1: 5B EF EF 01
  - row2: EF 5B 01 EF
  - row3: EF 01 EF 5B
  - z_row = XOR of coefficient·y_j over j.
- GF multiply rules:
  - xtime(a) = {a[6:0],0} ^ (a[7] ? POLY : 0).
  - 5B·a and EF·a are XORs of xtime powers of a, taken per the set bits of the constant.
  - Everything is pure combinational XOR logic; no integer arithmetic.
- State machine:
  - IDLE: when start=1, latch din into din_q, set row=0, go to CALC.
  - CALC: busy=1. Each cycle, compute z_row from din_q and write it into dout[8*row+:8], then row++. After writing row 3, go to DONE.
  - DONE: done=1 for exactly this one cycle, busy=0. If start=1, latch a new din, set row=0, go to CALC (back-to-back operation). Otherwise go to IDLE.
- Latency: start is sampled at edge N. Rows 0..3 are written at edges N+1..N+4. done is high between edges N+4 and N+5.
- Issue interval is 5 cycles back-to-back: start held high continuously yields a done pulse every 5 cycles.
- Ignored start: start during CALC is ignored; it is not queued.
- din stability: din is only sampled at acceptance, so changing din during CALC has no effect.
- dout while busy:
  - During CALC, dout bytes already written hold the new result.
  - Unwritten bytes hold the previous result.
  - dout is guaranteed complete only while done=1 and thereafter until the next accepted start.
- dout holding: dout holds its value indefinitely in IDLE.
- Mutual exclusion: busy and done are never high together.

Test Plan:
- Reset: rst_n=0 with random din/start -> dout=0x00000000, busy=0, done=0. Release, start=0 for 10 cycles -> no change.
- Unit vectors:
  - din=0x00000001 -> dout=0xEFEF5B01.
  - din=0x00000100 -> dout=0x015BEFEF.
  - Each done is high exactly 4 edges after the start edge, for 1 cycle.
- Reduction check: din=0x00000002 -> dout=0xB7B7B602, exercising the EF·02 reduction (0x1DE^0x169=0xB7). din=0x01010101 -> dout=0x5A5A5AEE.
- Exhaustive per-byte sweep:
  - For each byte lane k and each value v in 0..255, drive din = v<<(8k).
  - Compare dout against a bench model built from xtime.
  - Write each result to a text file in %b for diffing against the golden model.
- Handshake: pulse start during CALC with a different din -> ignored, result unchanged. Hold start high with 3 queued vectors -> done pulses 5 cycles apart, each dout correct.
- Abort: assert rst_n=0 at the edge after row 1 is written, then release -> IDLE, dout=0, no done. A fresh start after release gives a correct result.
